// File: rtl/coherence_bus_ctrl_pkg.sv
`default_nettype none
// ==================================================================
// coherence_bus_ctrl_pkg : shared types for the coherence bus controller
// Rev 1.0
// ==================================================================
package coherence_bus_ctrl_pkg;

  localparam int unsigned WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    SNOOP  = 4'd1,
    SWB0   = 4'd2,
    SWB1   = 4'd3,
    EVICT0 = 4'd4,
    EVICT1 = 4'd5,
    FILL0  = 4'd6,
    FILL1  = 4'd7,
    IFETCH = 4'd8
  } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/coherence_bus_ctrl_rr_arb.sv
`default_nettype none
// ==================================================================
// coherence_bus_ctrl_rr_arb : 2-way round-robin arbiter, pointer toggles on adv
// Rev 1.0
// ==================================================================
module coherence_bus_ctrl_rr_arb
  import coherence_bus_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       adv,
  output logic       gnt
);

  logic ptr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= 1'b0;
    end else if (adv) begin
      ptr <= ~ptr;
    end
  end

  // The pointer only decides a tie; a lone requester always wins.
  always_comb begin
    gnt = ptr;
    if (req == 2'b01) begin
      gnt = 1'b0;
    end else if (req == 2'b10) begin
      gnt = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/coherence_bus_ctrl.sv
`default_nettype none
// ==================================================================
// coherence_bus_ctrl : two-core MSI snooping bus controller and RAM arbiter
// Build option C2C_XFER_EN forwards snoop write-back words to the requester.
// Rev 1.0
// ==================================================================
module coherence_bus_ctrl
  import coherence_bus_ctrl_pkg::*;
#(
  parameter int unsigned BLK_WORDS = 2,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NCORE     = 2
)
(
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NCORE-1:0]              iREN,
  input  logic [NCORE-1:0][WORD_W-1:0]  iaddr,
  output logic [NCORE-1:0]              iwait,
  output logic [NCORE-1:0][WORD_W-1:0]  iload,
  input  logic [NCORE-1:0]              dREN,
  input  logic [NCORE-1:0]              dWEN,
  input  logic [NCORE-1:0][WORD_W-1:0]  daddr,
  input  logic [NCORE-1:0][WORD_W-1:0]  dstore,
  output logic [NCORE-1:0]              dwait,
  output logic [NCORE-1:0][WORD_W-1:0]  dload,
  input  logic [NCORE-1:0]              cctrans,
  input  logic [NCORE-1:0]              ccwrite,
  output logic [NCORE-1:0]              ccwait,
  output logic [NCORE-1:0]              ccinv,
  output logic [NCORE-1:0][WORD_W-1:0]  ccsnoopaddr,
  output logic                          ramREN,
  output logic                          ramWEN,
  output logic [WORD_W-1:0]             ramaddr,
  output logic [WORD_W-1:0]             ramstore,
  input  logic [WORD_W-1:0]             ramload,
  input  logic                          ramready
);

  localparam logic [WORD_W-1:0] BLK_MASK = WORD_W'(BLK_WORDS * 4 - 1);

  bus_state_t        state_q, state_d;
  logic              req_q, req_d;       // data requester r
  logic              snp_core;           // snooped core s
  logic              ifc_q, ifc_d;       // instruction requester
  logic              upg_q, upg_d;
  logic              inv_q, inv_d;
  logic [WORD_W-1:0] snp_addr_q, snp_addr_d;

  logic [NCORE-1:0]  cc_req, ev_req, rd_req, dreq;
  logic              dgnt, igrant;
  logic              dadv, iadv;

  assign snp_core = ~req_q;

  assign cc_req = cctrans;
  assign ev_req = dWEN & ~cctrans;
  assign rd_req = dREN & ~cctrans;

  always_comb begin
    if (|cc_req) begin
      dreq = cc_req;
    end else if (|ev_req) begin
      dreq = ev_req;
    end else begin
      dreq = rd_req;
    end
  end

  assign dadv = (state_q == IDLE) && (|dreq);
  assign iadv = (state_q == IDLE) && !(|dreq) && (|iREN);

  coherence_bus_ctrl_rr_arb u_data_arb (
    .CLK (CLK),
    .RST (RST),
    .req (dreq),
    .adv (dadv),
    .gnt (dgnt)
  );

  coherence_bus_ctrl_rr_arb u_inst_arb (
    .CLK (CLK),
    .RST (RST),
    .req (iREN),
    .adv (iadv),
    .gnt (igrant)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      ifc_q      <= 1'b0;
      upg_q      <= 1'b0;
      inv_q      <= 1'b0;
      snp_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      ifc_q      <= ifc_d;
      upg_q      <= upg_d;
      inv_q      <= inv_d;
      snp_addr_q <= snp_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    ifc_d       = ifc_q;
    upg_d       = upg_q;
    inv_d       = inv_q;
    snp_addr_d  = snp_addr_q;
    iwait       = '1;
    iload       = '0;
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    unique case (state_q)
      IDLE: begin
        if (|dreq) begin
          // Requester identity and intent are frozen here so a dropped request cannot derail the transaction.
          req_d      = dgnt;
          upg_d      = cctrans[dgnt] & ccwrite[dgnt] & ~dREN[dgnt];
          inv_d      = ccwrite[dgnt];
          snp_addr_d = daddr[dgnt] & ~BLK_MASK;
          if (|cc_req) begin
            state_d = SNOOP;
          end else if (|ev_req) begin
            state_d = EVICT0;
          end else begin
            state_d = FILL0;
          end
        end else if (|iREN) begin
          ifc_d   = igrant;
          state_d = IFETCH;
        end
      end

      SNOOP: begin
        ccwait[snp_core]      = 1'b1;
        ccinv[snp_core]       = inv_q;
        ccsnoopaddr[snp_core] = snp_addr_q;
        if (ccwrite[snp_core]) begin
          state_d = SWB0;
        end else if (upg_q) begin
          dwait[req_q] = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = FILL0;
        end
      end

      SWB0, SWB1: begin
        ccwait[snp_core]      = 1'b1;
        ccinv[snp_core]       = inv_q;
        ccsnoopaddr[snp_core] = snp_addr_q;
        ramWEN                = 1'b1;
        ramaddr               = daddr[snp_core];
        ramstore              = dstore[snp_core];
        if (ramready) begin
          dwait[snp_core] = 1'b0;
`ifdef C2C_XFER_EN
          if (!upg_q) begin
            dload[req_q] = dstore[snp_core];
            dwait[req_q] = 1'b0;
          end
`endif
          if (state_q == SWB0) begin
            state_d = SWB1;
          end else if (upg_q) begin
            dwait[req_q] = 1'b0;
            state_d      = IDLE;
          end else begin
`ifdef C2C_XFER_EN
            state_d = IDLE;
`else
            state_d = FILL0;
`endif
          end
        end
      end

      EVICT0, EVICT1: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[req_q];
        ramstore = dstore[req_q];
        if (ramready) begin
          dwait[req_q] = 1'b0;
          state_d      = (state_q == EVICT0) ? EVICT1 : IDLE;
        end
      end

      FILL0, FILL1: begin
        ramREN  = 1'b1;
        ramaddr = daddr[req_q];
        if (ramready) begin
          dload[req_q] = ramload;
          dwait[req_q] = 1'b0;
          state_d      = (state_q == FILL0) ? FILL1 : IDLE;
        end
      end

      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[ifc_q];
        if (ramready) begin
          iload[ifc_q] = ramload;
          iwait[ifc_q] = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_coherence_bus_ctrl.sv
`default_nettype none
// ==================================================================
// tb_coherence_bus_ctrl : directed self-checking bench for coherence_bus_ctrl
// Rev 1.0
// ==================================================================
module tb_coherence_bus_ctrl;

  logic             CLK;
  logic             RST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic [1:0]       dREN;
  logic [1:0]       dWEN;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]       dwait;
  logic [1:0][31:0] dload;
  logic [1:0]       cctrans;
  logic [1:0]       ccwrite;
  logic [1:0]       ccwait;
  logic [1:0]       ccinv;
  logic [1:0][31:0] ccsnoopaddr;
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  logic             ramready;

  int   tests = 0;
  int   fails = 0;
  logic both_seen = 1'b0;

  coherence_bus_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .iREN        (iREN),
    .iaddr       (iaddr),
    .iwait       (iwait),
    .iload       (iload),
    .dREN        (dREN),
    .dWEN        (dWEN),
    .daddr       (daddr),
    .dstore      (dstore),
    .dwait       (dwait),
    .dload       (dload),
    .cctrans     (cctrans),
    .ccwrite     (ccwrite),
    .ccwait      (ccwait),
    .ccinv       (ccinv),
    .ccsnoopaddr (ccsnoopaddr),
    .ramREN      (ramREN),
    .ramWEN      (ramWEN),
    .ramaddr     (ramaddr),
    .ramstore    (ramstore),
    .ramload     (ramload),
    .ramready    (ramready)
  );

  // RAM contents: word at address A reads as 0xD000_AAAA.
  assign ramload = {16'hD000, ramaddr[15:0]};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (ramREN && ramWEN) both_seen <= 1'b1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
    cctrans = '0; ccwrite = '0; ramready = 1'b1;

    // Reset values
    tick(); tick(); settle();
    check("rst_dwait",    64'(dwait), 64'h3);
    check("rst_iwait",    64'(iwait), 64'h3);
    check("rst_ccwait",   64'(ccwait), 64'h0);
    check("rst_ccinv",    64'(ccinv), 64'h0);
    check("rst_ram_en",   64'({ramREN, ramWEN}), 64'h0);
    check("rst_ramaddr",  64'(ramaddr), 64'h0);
    check("rst_ramstore", 64'(ramstore), 64'h0);
    check("rst_snpaddr",  ccsnoopaddr, 64'h0);
    RST = 1'b0;
    tick();

    // Read miss by core0 at 0x100, core1 clean
    cctrans = 2'b01; dREN = 2'b01; daddr[0] = 32'h100; settle();
    check("t1_idle_ram", 64'({ramREN, ramWEN}), 64'h0);
    tick(); settle();
    check("t1_snp_ccwait", 64'(ccwait), 64'h2);
    check("t1_snp_addr",   ccsnoopaddr, {32'h100, 32'h0});
    check("t1_snp_inv",    64'(ccinv), 64'h0);
    check("t1_snp_ram",    64'({ramREN, ramWEN}), 64'h0);
    tick(); settle();
    check("t1_f0_ram",    64'({ramREN, ramWEN}), 64'h2);
    check("t1_f0_addr",   64'(ramaddr), 64'h100);
    check("t1_f0_dwait",  64'(dwait), 64'h2);
    check("t1_f0_dload",  64'(dload[0]), 64'hD000_0100);
    check("t1_f0_ccwait", 64'(ccwait), 64'h0);
    tick(); daddr[0] = 32'h104; settle();
    check("t1_f1_addr",  64'(ramaddr), 64'h104);
    check("t1_f1_dload", 64'(dload[0]), 64'hD000_0104);
    tick(); cctrans = '0; dREN = '0; settle();
    check("t1_done_dwait", 64'(dwait), 64'h3);
    check("t1_done_ram",   64'({ramREN, ramWEN}), 64'h0);

    // Write miss by core0 at 0x200 while core1 holds it Modified
    cctrans = 2'b01; ccwrite = 2'b01; dREN = 2'b01; daddr[0] = 32'h200; settle();
    tick();
    ccwrite = 2'b11; daddr[1] = 32'h200; dstore[1] = 32'hCAFE_0200; settle();
    check("t2_snp_inv",    64'(ccinv), 64'h2);
    check("t2_snp_ccwait", 64'(ccwait), 64'h2);
    check("t2_snp_addr",   ccsnoopaddr, {32'h200, 32'h0});
    tick(); ramready = 1'b0; settle();
    check("t2_stall_ram",   64'({ramREN, ramWEN}), 64'h1);
    check("t2_stall_dwait", 64'(dwait), 64'h3);
    check("t2_swb0_addr",   64'(ramaddr), 64'h200);
    check("t2_swb0_store",  64'(ramstore), 64'hCAFE_0200);
    ramready = 1'b1; settle();
`ifdef C2C_XFER_EN
    check("t2_swb0_dwait", 64'(dwait), 64'h0);
    check("t2_swb0_fwd",   64'(dload[0]), 64'hCAFE_0200);
`else
    check("t2_swb0_dwait", 64'(dwait), 64'h1);
    check("t2_swb0_dload", 64'(dload[0]), 64'h0);
`endif
    tick(); daddr[1] = 32'h204; dstore[1] = 32'hCAFE_0204; settle();
    check("t2_swb1_addr",   64'(ramaddr), 64'h204);
    check("t2_swb1_store",  64'(ramstore), 64'hCAFE_0204);
    check("t2_swb1_ccwait", 64'(ccwait), 64'h2);
`ifdef C2C_XFER_EN
    check("t2_swb1_fwd", 64'(dload[0]), 64'hCAFE_0204);
    tick(); cctrans = '0; ccwrite = '0; dREN = '0; settle();
    check("t2_done_ccwait", 64'(ccwait), 64'h0);
    check("t2_done_ram",    64'({ramREN, ramWEN}), 64'h0);
    check("t2_done_dwait",  64'(dwait), 64'h3);
`else
    tick(); ccwrite = 2'b01; settle();
    check("t2_f0_ccwait", 64'(ccwait), 64'h0);
    check("t2_f0_ram",    64'({ramREN, ramWEN}), 64'h2);
    check("t2_f0_addr",   64'(ramaddr), 64'h200);
    check("t2_f0_dload",  64'(dload[0]), 64'hD000_0200);
    tick(); daddr[0] = 32'h204; settle();
    check("t2_f1_dload", 64'(dload[0]), 64'hD000_0204);
    tick(); cctrans = '0; ccwrite = '0; dREN = '0; settle();
    check("t2_done_dwait", 64'(dwait), 64'h3);
`endif

    // Upgrade S->M by core0, unaligned word address 0x304
    cctrans = 2'b01; ccwrite = 2'b01; daddr[0] = 32'h304; settle();
    tick(); settle();
    check("t3_snp_inv",   64'(ccinv), 64'h2);
    check("t3_snp_addr",  ccsnoopaddr, {32'h300, 32'h0});
    check("t3_snp_dwait", 64'(dwait), 64'h2);
    check("t3_snp_ram",   64'({ramREN, ramWEN}), 64'h0);
    tick(); cctrans = '0; ccwrite = '0; settle();
    check("t3_done_dwait",  64'(dwait), 64'h3);
    check("t3_done_ccwait", 64'(ccwait), 64'h0);

    // Eviction by core0 at 0x80 beats core1 instruction fetch at 0x40
    dWEN = 2'b01; daddr[0] = 32'h80; dstore[0] = 32'h1111_0080;
    iREN = 2'b10; iaddr[1] = 32'h40; settle();
    tick(); settle();
    check("t5_ev0_ram",   64'({ramREN, ramWEN}), 64'h1);
    check("t5_ev0_addr",  64'(ramaddr), 64'h80);
    check("t5_ev0_store", 64'(ramstore), 64'h1111_0080);
    check("t5_ev0_dwait", 64'(dwait), 64'h2);
    check("t5_ev0_iwait", 64'(iwait), 64'h3);
    tick(); daddr[0] = 32'h84; dstore[0] = 32'h1111_0084; settle();
    check("t5_ev1_addr",  64'(ramaddr), 64'h84);
    check("t5_ev1_store", 64'(ramstore), 64'h1111_0084);
    tick(); dWEN = '0; settle();
    check("t5_idle_ram", 64'({ramREN, ramWEN}), 64'h0);
    tick(); settle();
    check("t5_if_ram",   64'({ramREN, ramWEN}), 64'h2);
    check("t5_if_addr",  64'(ramaddr), 64'h40);
    check("t5_if_iwait", 64'(iwait), 64'h1);
    check("t5_if_iload", iload, {32'hD000_0040, 32'h0});
    tick(); iREN = '0; settle();
    check("t5_done_iwait", 64'(iwait), 64'h3);

    // Bare read by core1 at 0x500, reset lands during FILL1
    dREN = 2'b10; daddr[1] = 32'h500; settle();
    tick(); settle();
    check("t6_f0_ccwait", 64'(ccwait), 64'h0);
    check("t6_f0_ram",    64'({ramREN, ramWEN}), 64'h2);
    check("t6_f0_addr",   64'(ramaddr), 64'h500);
    check("t6_f0_dwait",  64'(dwait), 64'h1);
    check("t6_f0_dload",  64'(dload[1]), 64'hD000_0500);
    tick(); daddr[1] = 32'h504; RST = 1'b1; settle();
    check("t6_f1_addr", 64'(ramaddr), 64'h504);
    tick(); settle();
    check("t6_rst_ram",   64'({ramREN, ramWEN}), 64'h0);
    check("t6_rst_addr",  64'(ramaddr), 64'h0);
    check("t6_rst_dwait", 64'(dwait), 64'h3);
    check("t6_rst_dload", dload, 64'h0);
    RST = 1'b0; dREN = '0;
    tick();

    // Simultaneous misses after reset: core0 first, then core1
    cctrans = 2'b11; dREN = 2'b11; ccwrite = '0;
    daddr[0] = 32'h600; daddr[1] = 32'h700; settle();
    tick(); settle();
    check("t4_a_ccwait", 64'(ccwait), 64'h2);
    check("t4_a_snp",    ccsnoopaddr, {32'h600, 32'h0});
    tick(); settle();
    check("t4_a_f0_addr",  64'(ramaddr), 64'h600);
    check("t4_a_f0_dwait", 64'(dwait), 64'h2);
    tick(); daddr[0] = 32'h604; settle();
    tick(); cctrans = 2'b10; dREN = 2'b10; settle();
    tick(); settle();
    check("t4_b_ccwait", 64'(ccwait), 64'h1);
    check("t4_b_snp",    ccsnoopaddr, {32'h0, 32'h700});
    tick(); settle();
    check("t4_b_f0_addr",  64'(ramaddr), 64'h700);
    check("t4_b_f0_dwait", 64'(dwait), 64'h1);
    tick(); daddr[1] = 32'h704; settle();
    tick(); cctrans = '0; dREN = '0; settle();

    // One lone upgrade toggles the pointer, so the next tie goes to core1
    cctrans = 2'b01; ccwrite = 2'b01; daddr[0] = 32'h600; settle();
    tick(); tick();
    cctrans = 2'b11; dREN = 2'b11; ccwrite = '0; settle();
    tick(); settle();
    check("t4_c_ccwait", 64'(ccwait), 64'h1);
    check("t4_c_snp",    ccsnoopaddr, {32'h0, 32'h700});

    check("never_ren_and_wen", 64'(both_seen), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
